// File: rtl/fp_add_pkg.sv
// Shared constants and operand classification for the pipelined FP adder.
package fp_add_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;
    localparam int GRS_W          = 3;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero) return frac_zero ? CLS_ZERO : CLS_SUB;
        if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; cnt_o = WIDTH when the input is all zero.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
        end
    end

    assign zero_o = ~|in_i;

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754 adder/subtractor (align, add, normalise/round) with a global stall.
// FP_ADD_SUBNORMAL_EN selects gradual underflow; otherwise subnormals flush to zero.
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sub,
    input  logic [EXP_W+MAN_W:0]     operandX,
    input  logic [EXP_W+MAN_W:0]     operandY,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + GRS_W;
    localparam int SUM_W = EXT_W + 1;
    localparam int EE_W  = EXP_W + 2;
    localparam int CNT_W = $clog2(EXT_W + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_ADD_SUBNORMAL_EN
    localparam bit FTZ = 1'b0;
`else
    localparam bit FTZ = 1'b1;
`endif

    logic en;
    logic out_valid_q;
    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    logic             xs, ys;
    logic [EXP_W-1:0] xe, ye, xee, yee;
    logic [MAN_W-1:0] xf, yf;
    logic [SIG_W-1:0] xsig, ysig;
    fp_class_e        xc, yc;
    logic             ftz_in;

    assign {xs, xe, xf} = operandX;
    assign ys = operandY[W-1] ^ in_sub;
    assign {ye, yf} = operandY[W-2:0];
    assign xc = fp_classify(xe == '0, &xe, xf == '0);
    assign yc = fp_classify(ye == '0, &ye, yf == '0);

`ifdef FP_ADD_SUBNORMAL_EN
    assign xsig   = {xc == CLS_NORM, xf};
    assign ysig   = {yc == CLS_NORM, yf};
    assign xee    = (xc == CLS_SUB) ? EXP_W'(1) : xe;
    assign yee    = (yc == CLS_SUB) ? EXP_W'(1) : ye;
    assign ftz_in = 1'b0;
`else
    assign xsig   = (xc == CLS_NORM) ? {1'b1, xf} : '0;
    assign ysig   = (yc == CLS_NORM) ? {1'b1, yf} : '0;
    assign xee    = (xc == CLS_NORM) ? xe : '0;
    assign yee    = (yc == CLS_NORM) ? ye : '0;
    assign ftz_in = (xc == CLS_SUB) | (yc == CLS_SUB);
`endif

    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e, diff;
    logic [SIG_W-1:0] a_sig, b_sig;
    logic [EXT_W-1:0] b_ext, b_mask, b_al;

    always_comb begin
        if ({xee, xsig} >= {yee, ysig}) begin
            a_s = xs; a_e = xee; a_sig = xsig;
            b_s = ys; b_e = yee; b_sig = ysig;
        end else begin
            a_s = ys; a_e = yee; a_sig = ysig;
            b_s = xs; b_e = xee; b_sig = xsig;
        end
    end

    assign diff   = a_e - b_e;
    assign b_ext  = {b_sig, {GRS_W{1'b0}}};
    assign b_mask = ~({EXT_W{1'b1}} << diff);
    assign b_al   = (32'(diff) >= 32'(MAN_W + 3))
                  ? {{(EXT_W-1){1'b0}}, |b_sig}
                  : (b_ext >> diff) | {{(EXT_W-1){1'b0}}, |(b_ext & b_mask)};

    logic         spec;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;

    always_comb begin
        spec       = 1'b0;
        spec_res   = '0;
        spec_flags = '0;
        if (xc == CLS_NAN || yc == CLS_NAN) begin
            spec     = 1'b1;
            spec_res = QNAN;
            spec_flags[FLAG_INVALID] = (xc == CLS_NAN && !xf[MAN_W-1]) ||
                                       (yc == CLS_NAN && !yf[MAN_W-1]);
        end else if (xc == CLS_INF && yc == CLS_INF && xs != ys) begin
            spec     = 1'b1;
            spec_res = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (xc == CLS_INF) begin
            spec     = 1'b1;
            spec_res = {xs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (yc == CLS_INF) begin
            spec     = 1'b1;
            spec_res = {ys, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid_q, s1_spec_q, s1_sign_q, s1_sub_q, s1_ftz_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [W-1:0]     s1_spec_res_q;
    logic [3:0]       s1_spec_flags_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [EXT_W-1:0] s1_a_q, s1_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_spec_q <= 1'b0; s1_sign_q <= 1'b0;
            s1_sub_q <= 1'b0; s1_ftz_q <= 1'b0; s1_tag_q <= '0;
            s1_spec_res_q <= '0; s1_spec_flags_q <= '0; s1_exp_q <= '0;
            s1_a_q <= '0; s1_b_q <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid; s1_spec_q <= spec; s1_sign_q <= a_s;
            s1_sub_q <= a_s ^ b_s; s1_ftz_q <= ftz_in; s1_tag_q <= in_tag;
            s1_spec_res_q <= spec_res; s1_spec_flags_q <= spec_flags;
            s1_exp_q <= a_e; s1_a_q <= {a_sig, {GRS_W{1'b0}}}; s1_b_q <= b_al;
        end
    end

    // ---------------- stage 2: magnitude add/subtract ----------------
    logic [SUM_W-1:0] sum_d;
    assign sum_d = s1_sub_q ? ({1'b0, s1_a_q} - {1'b0, s1_b_q})
                            : ({1'b0, s1_a_q} + {1'b0, s1_b_q});

    logic             s2_valid_q, s2_spec_q, s2_sign_q, s2_sub_q, s2_ftz_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [W-1:0]     s2_spec_res_q;
    logic [3:0]       s2_spec_flags_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SUM_W-1:0] s2_sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0; s2_spec_q <= 1'b0; s2_sign_q <= 1'b0;
            s2_sub_q <= 1'b0; s2_ftz_q <= 1'b0; s2_tag_q <= '0;
            s2_spec_res_q <= '0; s2_spec_flags_q <= '0; s2_exp_q <= '0; s2_sum_q <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q; s2_spec_q <= s1_spec_q; s2_sign_q <= s1_sign_q;
            s2_sub_q <= s1_sub_q; s2_ftz_q <= s1_ftz_q; s2_tag_q <= s1_tag_q;
            s2_spec_res_q <= s1_spec_res_q; s2_spec_flags_q <= s1_spec_flags_q;
            s2_exp_q <= s1_exp_q; s2_sum_q <= sum_d;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [CNT_W-1:0] lz;
    logic             lo_zero, sum_zero;

    fp_lzc #(.WIDTH(EXT_W), .CNT_W(CNT_W)) u_lzc (
        .in_i   (s2_sum_q[EXT_W-1:0]),
        .cnt_o  (lz),
        .zero_o (lo_zero)
    );

    assign sum_zero = ~s2_sum_q[SUM_W-1] & lo_zero;

    logic [EE_W-1:0]  e_a, lz_e, e_n, e_r;
    logic [EXT_W-1:0] norm;
    logic             tiny;

    assign e_a  = EE_W'(s2_exp_q);
    assign lz_e = EE_W'(lz);

    // Tiny: the normalised result lands below the smallest normal exponent.
    always_comb begin
        norm = s2_sum_q[EXT_W-1:0];
        e_n  = e_a;
        tiny = 1'b0;
        if (s2_sum_q[SUM_W-1]) begin
            norm = {s2_sum_q[SUM_W-1:2], |s2_sum_q[1:0]};
            e_n  = e_a + EE_W'(1);
        end else if (lz_e < e_a) begin
            norm = s2_sum_q[EXT_W-1:0] << lz;
            e_n  = e_a - lz_e;
        end else begin
            tiny = 1'b1;
`ifdef FP_ADD_SUBNORMAL_EN
            norm = s2_sum_q[EXT_W-1:0] << (e_a - EE_W'(1));
            e_n  = EE_W'(1);
`else
            norm = '0;
`endif
        end
    end

    logic [SIG_W-1:0] sig_n;
    logic [SIG_W:0]   sig_r;
    logic             rnd_up, inexact, implicit_r, ovf;
    logic [MAN_W-1:0] frac_r;

    assign sig_n      = norm[EXT_W-1:GRS_W];
    assign rnd_up     = norm[2] & (norm[1] | norm[0] | sig_n[0]);
    assign inexact    = |norm[GRS_W-1:0] | s2_ftz_q;
    assign sig_r      = {1'b0, sig_n} + (SIG_W+1)'(rnd_up);
    assign e_r        = sig_r[SIG_W] ? e_n + EE_W'(1) : e_n;
    assign frac_r     = sig_r[SIG_W] ? '0 : sig_r[MAN_W-1:0];
    assign implicit_r = sig_r[SIG_W] | sig_r[MAN_W];
    assign ovf        = e_r >= EE_W'({EXP_W{1'b1}});

    logic [W-1:0] result_d;
    logic [3:0]   flags_d;

    always_comb begin
        result_d = {s2_sign_q, implicit_r ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}, frac_r};
        flags_d  = '0;
        flags_d[FLAG_INEXACT]   = inexact;
        flags_d[FLAG_UNDERFLOW] = tiny & inexact;
        if (s2_spec_q) begin
            result_d = s2_spec_res_q;
            flags_d  = s2_spec_flags_q;
        end else if (sum_zero) begin
            result_d = {s2_sign_q & ~s2_sub_q, {(W-1){1'b0}}};
            flags_d  = '0;
            flags_d[FLAG_UNDERFLOW] = s2_ftz_q;
            flags_d[FLAG_INEXACT]   = s2_ftz_q;
        end else if (FTZ && tiny) begin
            result_d = {s2_sign_q, {(W-1){1'b0}}};
            flags_d  = '0;
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end else if (ovf) begin
            result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d  = '0;
            flags_d[FLAG_OVERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]  = 1'b1;
        end
    end

    logic [W-1:0]     result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [3:0]       flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
            flags_q     <= '0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            result_q    <= result_d;
            out_tag_q   <= s2_tag_q;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: vector table streamed through a scoreboard,
// plus latency, stall, mid-stream reset and binary64 sequences.
module tb_fp_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] opx, opy, result;
    logic [3:0]  in_tag, out_tag, flags;

    logic        v_in_valid, v_in_ready, v_in_sub, v_out_valid, v_out_ready;
    logic [63:0] v_opx, v_opy, v_result;
    logic [3:0]  v_in_tag, v_out_tag, v_flags;

    fp_add_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .operandX(opx), .operandY(opy), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .flags(flags)
    );

    fp_add_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_sub(v_in_sub), .operandX(v_opx), .operandY(v_opy), .in_tag(v_in_tag),
        .out_valid(v_out_valid), .out_ready(v_out_ready), .result(v_result),
        .out_tag(v_out_tag), .flags(v_flags)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    localparam int NV = 18;
    vec_t vecs[NV];
    exp_t sbq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sb_step();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", 64'(result), 64'hDEAD);
            end else begin
                e = sbq.pop_front();
                check($sformatf("stream_tag%0d {result,flags,tag}", e.tag),
                      64'({result, flags, out_tag}), 64'({e.res, e.flg, e.tag}));
            end
        end
    endtask

    initial begin
        int lat;
        bit got;
        int idx, cyc;
        logic [39:0] held;
        bit stale;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[3]  = '{32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[5]  = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000};
        vecs[6]  = '{32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 4'b0000};
`ifdef FP_ADD_SUBNORMAL_EN
        vecs[7]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000};
        vecs[17] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000};
`else
        vecs[7]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0011};
        vecs[17] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
`endif
        vecs[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vecs[9]  = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
        vecs[12] = '{32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 4'b0000};
        vecs[13] = '{32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000};
        vecs[14] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001};
        vecs[15] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0001};
        vecs[16] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001};

        rst_n = 1'b0;
        in_valid = 1'b0; in_sub = 1'b0; opx = '0; opy = '0; in_tag = '0; out_ready = 1'b1;
        v_in_valid = 1'b0; v_in_sub = 1'b0; v_opx = '0; v_opy = '0; v_in_tag = '0;
        v_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Single op latency.
        @(negedge clk);
        in_valid = 1'b1; opx = 32'h3F800000; opy = 32'h3F800000; in_sub = 1'b0; in_tag = 4'd5;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            in_valid = 1'b0;
            if (out_valid) got = 1'b1;
        end
        check("latency_cycles", 64'(lat), 64'd3);
        check("latency_result", 64'(result), 64'h40000000);
        check("latency_flags", 64'(flags), 64'd0);
        check("latency_tag", 64'(out_tag), 64'd5);
        @(negedge clk);
        @(negedge clk);

        // Table streamed back-to-back, consumer stalls in cycles 4..6.
        idx = 0; cyc = 0; held = '0;
        while ((idx < NV || sbq.size() > 0) && cyc < 200) begin
            in_valid  = (idx < NV);
            if (idx < NV) begin
                opx = vecs[idx].x; opy = vecs[idx].y; in_sub = vecs[idx].sub;
                in_tag = 4'(idx);
            end
            out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            check($sformatf("in_ready_cyc%0d", cyc), 64'(in_ready),
                  64'(!(cyc >= 4 && cyc <= 6)));
            if (cyc == 4) held = {result, flags, out_tag};
            if (cyc == 5 || cyc == 6)
                check($sformatf("stall_hold_cyc%0d", cyc),
                      64'({result, flags, out_tag}), 64'(held));
            sb_step();
            if (in_valid && in_ready) begin
                sbq.push_back('{vecs[idx].res, vecs[idx].flg, 4'(idx)});
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_complete", 64'(idx + sbq.size()), 64'(NV));

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; opx = vecs[i].x; opy = vecs[i].y; in_sub = vecs[i].sub;
            in_tag = 4'(i + 8);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check("mid_reset_result", 64'(result), 64'd0);
        check("mid_reset_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_after_reset", 64'(stale), 64'd0);

        // binary64 1.0 + 1.0
        @(negedge clk);
        v_in_valid = 1'b1; v_opx = 64'h3FF0000000000000; v_opy = 64'h3FF0000000000000;
        v_in_tag = 4'd9;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            v_in_valid = 1'b0;
            if (v_out_valid) got = 1'b1;
        end
        check("b64_latency", 64'(lat), 64'd3);
        check("b64_result", v_result, 64'h4000000000000000);
        check("b64_flags", 64'(v_flags), 64'd0);
        check("b64_tag", 64'(v_out_tag), 64'd9);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Pipelined, parametrised IEEE-754 binary floating-point adder/subtractor. It is the streaming successor to the team's combinational `fp_adder`. Widths are generic (default binary32), with a valid/ready handshake, a per-operation add/subtract select, round-to-nearest-even, and exception flags. It sits between the operand-issue logic and the result writeback in the FP datapath, and sustains one operation per cycle when unstalled.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored fraction width (≥2). Word width `W = 1+EXP_W+MAN_W`.
- `TAG_W`, default 4: opaque sideband tag carried with each operation.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block accepts operation this cycle.
- `in_sub`  in  1  0: X+Y; 1: X−Y (sign of Y inverted before processing).
- `operandX`, `operandY`  in  W  IEEE operands.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result presented.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  W  rounded sum.
- `out_tag`  out  TAG_W  tag of this result.
- `flags`  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- Stage 1 (unpack/align): classify (zero, subnormal, normal, inf, NaN). Swap so the larger magnitude is first. Right-shift the smaller significand by the exponent difference into guard/round/sticky. Shifts ≥ MAN_W+3 collapse to sticky only.
- Stage 2 (add): effective add or subtract of `MAN_W+4`-bit extended significands. The result sign is the larger operand's sign.
- Stage 3 (normalise/round): leading-zero count, then left shift, or a 1-bit right shift on carry-out. RNE on guard/round/sticky. Re-normalise on a rounding carry. Pack.
- Special cases, decided in stage 1 and carried as an override:
  - Any NaN input → canonical qNaN: sign 0, exp all-ones, fraction MSB 1, rest 0 (0x7FC00000 for binary32). invalid=1 only for signalling NaN inputs.
  - +inf + −inf (after `in_sub`) → canonical qNaN, invalid=1.
  - inf + finite → that inf. Same-sign infs → that inf.
  - Exact zero sum of opposite-sign operands → +0. (−0)+(−0) → −0.
  - Exponent overflow after rounding → ±inf, overflow=1, inexact=1.
- inexact = any nonzero guard/round/sticky discarded. underflow = tiny result and inexact.

## Timing
- Latency is exactly 3 cycles from an accepted input (`in_valid & in_ready`) to `out_valid`, when unstalled.
- Global stall: `in_ready = ~out_valid | out_ready`. While stalled, all three stages hold and `result`/`out_tag`/`flags` stay stable.
- Bubbles propagate as valid=0. Bubbles are not collapsed under stall.
- Throughput is 1 op/cycle with `out_ready` held high. Accept and emit in the same cycle is legal.
- `out_valid` must not depend combinationally on `in_valid`. `in_ready` depends only on `out_valid` and `out_ready`.
- Reset (asynchronous, any time, including mid-stream): all stage valids=0, `out_valid=0`, `result=0`, `out_tag=0`, `flags=0`, `in_ready=1` after deassertion. In-flight operations are discarded.

## Configuration
- `FP_ADD_SUBNORMAL_EN` defined: full gradual underflow. Subnormal inputs use an implicit bit of 0 and exponent 1. Subnormal results are produced, so 0x00000001+0x00000001 = 0x00000002.
- Undefined: flush-to-zero. Subnormal inputs are treated as same-sign zero. Subnormal results are flushed to same-sign zero with underflow=1 and inexact=1. This removes the subnormal shift path from stage 3.

## Structure
- `fp_add_pkg`: flag bit indices (`FLAG_INVALID=3`, `FLAG_OVERFLOW=2`, `FLAG_UNDERFLOW=1`, `FLAG_INEXACT=0`), operand class enum, and a guard/round/sticky width constant (3).
- Sub-module `fp_lzc`: parametrised leading-zero counter (`WIDTH` parameter; outputs count and all-zero), instantiated in stage 3.

## Test plan
- 0x3F800000 + 0x3F800000, `out_ready`=1: `result`=0x40000000, `flags`=0, `out_valid` exactly 3 cycles after acceptance.
- Ten back-to-back ops with `out_ready` low for cycles 4–6: no loss or duplication, results in order with matching `out_tag`, `in_ready` low exactly during the stall.
- Rounding, inexact=1 in both:
  - 0x3F800000+0x33800000 → 0x3F800000 (tie to even).
  - 0x3F800001+0x33800000 → 0x3F800002.
- Specials:
  - 0xFF800000+0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow=1.
  - 0xBF800000+0x3F800000 → 0x00000000.
  - `in_sub`=1 with 0x40400000,0x40000000 → 0x3F800000.
- Subnormals: 0x00000001+0x00000001 → 0x00000002 with `FP_ADD_SUBNORMAL_EN` defined, 0x00000000 with underflow=1 without it.
- Assert `rst_n` low with 3 ops in flight: `out_valid` drops immediately, `result`=0, and no stale result emerges after release. Repeat binary64 (`EXP_W`=11, `MAN_W`=52): 1.0+1.0 → 0x4000000000000000.
